// File: rtl/i2c_pkg.sv
`default_nettype none
// ==================================================================
// i2c_pkg : FSM encoding and bus field widths for the i2c arbiter
// Revision 1.0
// ==================================================================
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LAUNCH    = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;
  localparam logic [1:0] COMPLETE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ==================================================================
// rr_picker : combinational round-robin winner select, search from ptr+1
// Revision 1.0
// ==================================================================
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] win,
  output logic             valid
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = '0;
    // k = N_REQ lands back on ptr itself, so the last owner is searched last
    for (int k = 1; k <= N_REQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!valid && req[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_arbiter.sv
`default_nettype none
// ==================================================================
// i2c_arbiter : round-robin sharing of one i2c master among N_REQ requesters
// Revision 1.0
// ==================================================================
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int LAUNCH_CYCLES  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [ADDR_W*N_REQ-1:0]   req_addr,
  input  logic [DATA_W*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_rw,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic [N_REQ-1:0]          err,
  output logic                      i2c_start,
  output logic [ADDR_W-1:0]         i2c_addr,
  output logic [DATA_W-1:0]         i2c_data,
  output logic                      i2c_rw,
  input  logic                      i2c_ready,
  output logic                      busy
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] LAUNCH_LIM  = CNT_W'(LAUNCH_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [PTR_W-1:0] PTR_RST     = PTR_W'(N_REQ - 1);

  logic [1:0]        state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  win_idx_q, win_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              err_flag_q, err_flag_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rw_q, rw_d;

  logic [N_REQ-1:0]  pick_win;
  logic              pick_valid;

  rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_picker (
    .req   (req),
    .ptr   (ptr_q),
    .win   (pick_win),
    .valid (pick_valid)
  );

  always_comb begin
    cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    state_d    = state_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    win_idx_d  = win_idx_q;
    cnt_d      = cnt_q;
    err_flag_d = err_flag_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rw_d       = rw_q;

    case (state_q)
      IDLE: begin
        if (pick_valid && i2c_ready) begin
          state_d    = LAUNCH;
          gnt_d      = pick_win;
          cnt_d      = '0;
          err_flag_d = 1'b0;
          for (int i = 0; i < N_REQ; i++) begin
            if (pick_win[i]) begin
              win_idx_d = PTR_W'(i);
              addr_d    = req_addr[i*ADDR_W +: ADDR_W];
              data_d    = req_data[i*DATA_W +: DATA_W];
              rw_d      = req_rw[i];
            end
          end
        end
      end
      LAUNCH: begin
        if (!i2c_ready) begin
          state_d = WAIT_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= LAUNCH_LIM) begin
            state_d    = COMPLETE;
            err_flag_d = 1'b1;
          end
        end
      end
      WAIT_DONE: begin
        if (i2c_ready) begin
          state_d = COMPLETE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= TIMEOUT_LIM) begin
            state_d    = COMPLETE;
            err_flag_d = 1'b1;
          end
        end
      end
      COMPLETE: begin
        gnt_d   = '0;
        ptr_d   = win_idx_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      ptr_q      <= PTR_RST;
      win_idx_q  <= '0;
      cnt_q      <= '0;
      err_flag_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rw_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      win_idx_q  <= win_idx_d;
      cnt_q      <= cnt_d;
      err_flag_q <= err_flag_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rw_q       <= rw_d;
    end
  end

  // gnt is still held during COMPLETE, so done/err reuse it as the one-hot
  assign gnt       = gnt_q;
  assign done      = (state_q == COMPLETE) ? gnt_q : '0;
  assign err       = (state_q == COMPLETE && err_flag_q) ? gnt_q : '0;
  assign i2c_start = (state_q == LAUNCH);
  assign busy      = (state_q != IDLE);
  assign i2c_addr  = addr_q;
  assign i2c_data  = data_q;
  assign i2c_rw    = rw_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_arbiter.sv
`default_nettype none
// ==================================================================
// tb_i2c_arbiter : vector table, corner sequences and random traffic vs. model
// Revision 1.0
// ==================================================================
module tb_i2c_arbiter;

  localparam int N  = 4;
  localparam int T  = 1024;
  localparam int L  = 4;
  localparam int AW = 7 * N;
  localparam int DW = 8 * N;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic [N-1:0]  req_rw;
  logic          i2c_ready;
  logic [N-1:0]  gnt, done, err;
  logic          i2c_start, i2c_rw, busy;
  logic [6:0]    i2c_addr;
  logic [7:0]    i2c_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  i2c_arbiter #(
    .N_REQ          (N),
    .TIMEOUT_CYCLES (T),
    .LAUNCH_CYCLES  (L)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_rw    (req_rw),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .i2c_start (i2c_start),
    .i2c_addr  (i2c_addr),
    .i2c_data  (i2c_data),
    .i2c_rw    (i2c_rw),
    .i2c_ready (i2c_ready),
    .busy      (busy)
  );

  int total = 0;
  int bad   = 0;

  // master behaviour for the next transaction: busy for cfg_hold cycles, or never leave idle
  int cfg_hold  = 1;
  bit cfg_never = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Transaction-level reference: a grant fixes its whole timeline from the master behaviour
  int         t = 0;
  int         m_owner = -1;
  int         m_last = N - 1;
  int         m_t0 = 0;
  int         m_td = 0;
  int         m_ret = 0;
  bit         m_err = 1'b0;
  bit         m_never = 1'b0;
  logic [6:0] m_addr = '0;
  logic [7:0] m_data = '0;
  logic       m_rw = 1'b0;

  int         ev_cnt = 0;
  int         ev_idx = -1;
  int         ev_lat = 0;
  bit         ev_err = 1'b0;
  int         t_rise = 0;
  logic [N-1:0] g_prev = '0;

  logic [N-1:0] oh;
  logic         m_start;
  logic [29:0]  exp_v, act_v;

  initial begin
    i2c_ready = 1'b1;
    forever begin
      @(negedge clk);
      t++;
      if (!rst) begin
        m_owner = -1;
        m_last  = N - 1;
        m_addr  = '0;
        m_data  = '0;
        m_rw    = 1'b0;
        m_ret   = 0;
      end else if (m_owner >= 0) begin
        if (t == m_td + 1) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end else if (req != '0 && i2c_ready) begin
        m_owner = rr_pick(req, m_last);
        m_addr  = req_addr[7*m_owner +: 7];
        m_data  = req_data[8*m_owner +: 8];
        m_rw    = req_rw[m_owner];
        m_t0    = t;
        m_never = cfg_never;
        if (cfg_never) begin
          m_td  = t + L;
          m_err = 1'b1;
        end else begin
          m_td  = t + ((cfg_hold > T) ? T : cfg_hold) + 1;
          m_err = (cfg_hold > T);
          m_ret = t + cfg_hold;
        end
      end

      oh = '0;
      if (m_owner >= 0) oh[m_owner] = 1'b1;
      m_start = (m_owner >= 0) && (m_never ? (t < m_t0 + L) : (t == m_t0));
      exp_v = {oh,
               (m_owner >= 0 && t == m_td) ? oh : {N{1'b0}},
               (m_owner >= 0 && t == m_td && m_err) ? oh : {N{1'b0}},
               m_start, (m_owner >= 0), m_addr, m_data, m_rw};
      act_v = {gnt, done, err, i2c_start, busy, i2c_addr, i2c_data, i2c_rw};
      check($sformatf("cycle%0d", t), 64'(act_v), 64'(exp_v));

      if (gnt != '0 && g_prev == '0) t_rise = t;
      if (done != '0) begin
        ev_cnt++;
        ev_idx = oh_idx(done);
        ev_err = |err;
        ev_lat = t - t_rise;
      end
      g_prev = gnt;

      i2c_ready = (t >= m_ret);
    end
  end

  task automatic wait_done(input int budget, input string name, output bit ok);
    int start;
    start = ev_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (ev_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: no done within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (!busy && i2c_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: arbiter/master not idle within 2000 cycles", name);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [6:0]   addr;
    logic [7:0]   data;
    logic         rw;
    int           hold;
    bit           never;
    int           exp_idx;
    bit           exp_err;
    int           exp_lat;
  } vec_t;

  vec_t vecs [8];
  int   rr_exp [5];

  initial begin
    bit ok;
    vecs[0] = '{4'b0010, 7'h50, 8'hA5, 1'b0,   20, 1'b0, 1, 1'b0,   21};
    vecs[1] = '{4'b0101, 7'h11, 8'h3C, 1'b1,    5, 1'b0, 2, 1'b0,    6};
    vecs[2] = '{4'b0101, 7'h22, 8'h81, 1'b0,    1, 1'b0, 0, 1'b0,    2};
    vecs[3] = '{4'b0101, 7'h7F, 8'hFF, 1'b1,    3, 1'b0, 2, 1'b0,    4};
    vecs[4] = '{4'b1000, 7'h05, 8'h00, 1'b0,    1, 1'b1, 3, 1'b1,    L};
    vecs[5] = '{4'b0001, 7'h33, 8'h5A, 1'b1,    T, 1'b0, 0, 1'b0,  T+1};
    vecs[6] = '{4'b0010, 7'h44, 8'hC3, 1'b0,  T+1, 1'b0, 1, 1'b1,  T+1};
    vecs[7] = '{4'b0100, 7'h66, 8'h96, 1'b1,    2, 1'b0, 2, 1'b0,    3};
    rr_exp  = '{0, 1, 2, 3, 0};

    rst = 1'b0;
    req = '0;
    req_addr = '0;
    req_data = '0;
    req_rw = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", 64'({gnt, done, err, i2c_start, busy, i2c_addr, i2c_data, i2c_rw}), 64'(0));
    rst = 1'b1;

    for (int v = 0; v < 8; v++) begin
      cfg_hold  = vecs[v].hold;
      cfg_never = vecs[v].never;
      req_addr  = {N{vecs[v].addr}};
      req_data  = {N{vecs[v].data}};
      req_rw    = {N{vecs[v].rw}};
      req       = vecs[v].req;
      wait_done(3000, $sformatf("vec%0d_done", v), ok);
      req = '0;
      if (ok) begin
        check($sformatf("vec%0d_winner", v), 64'(ev_idx), 64'(vecs[v].exp_idx));
        check($sformatf("vec%0d_err", v), 64'(ev_err), 64'(vecs[v].exp_err));
        check($sformatf("vec%0d_latency", v), 64'(ev_lat), 64'(vecs[v].exp_lat));
        check($sformatf("vec%0d_addr", v), 64'(i2c_addr), 64'(vecs[v].addr));
        check($sformatf("vec%0d_data", v), 64'(i2c_data), 64'(vecs[v].data));
      end
      wait_idle($sformatf("vec%0d_idle", v));
    end

    // all four requesting continuously after reset
    do_reset();
    cfg_hold  = 2;
    cfg_never = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done(100, $sformatf("rr%0d_done", k), ok);
      if (ok) check($sformatf("rr%0d_winner", k), 64'(ev_idx), 64'(rr_exp[k]));
    end
    req = '0;
    wait_idle("rr_idle");

    // reset while the master is busy
    cfg_hold = 50;
    req = 4'b0001;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (busy && !i2c_start) begin
        ok = 1'b1;
        break;
      end
    end
    check("mid_reset_reached_wait", 64'(ok), 64'(1));
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check("mid_reset_gnt", 64'(gnt), 64'(0));
    check("mid_reset_start", 64'(i2c_start), 64'(0));
    check("mid_reset_busy", 64'(busy), 64'(0));
    check("mid_reset_done", 64'(done), 64'(0));
    rst = 1'b1;
    cfg_hold = 2;
    req = 4'b1111;
    wait_done(100, "post_reset_done", ok);
    if (ok) check("post_reset_winner", 64'(ev_idx), 64'(0));
    req = '0;
    wait_idle("post_reset_idle");

    // randomized traffic: requesters hold until their done, may drop while granted
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(3) == 0) req[i] = 1'b1;
        end else if (done[i]) begin
          if ($urandom_range(1) == 0) req[i] = 1'b0;
        end else if (gnt[i] && $urandom_range(15) == 0) begin
          req[i] = 1'b0;
        end
      end
      req_addr  = AW'($urandom);
      req_data  = DW'($urandom);
      req_rw    = N'($urandom);
      cfg_hold  = $urandom_range(30, 1);
      cfg_never = ($urandom_range(19) == 0);
    end
    req = '0;
    wait_idle("random_idle");
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
